// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO store port: FSM states, register offsets, default window base.
// Also carries the window-hit helper used by the decode.
package mmio_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } mmio_state_t;

  localparam logic [7:0]  MMIO_TX_OFS   = 8'h00;
  localparam logic [7:0]  MMIO_HALT_OFS = 8'hFC;
  localparam logic [31:0] MMIO_BASE     = 32'h0000_FF00;

  // The window is one 256-byte page; only the page bits take part in the match.
  function automatic logic mmio_hit(input logic [31:0] adr, input logic [31:0] base);
    return adr[31:8] == base[31:8];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered storage with combinational head read; push visible at the output after one edge.
// Caller must not push when full unless popping the same cycle; full+push+pop writes the slot being vacated.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is reset too so the head word reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count    = wr_ptr - rd_ptr;
  assign head_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_store_port.sv
// MMIO store port: decodes core stores into a TX FIFO (drained over valid/ready) and a HALT register; out_valid one edge after a TX store.
// TX stores are dropped (and counted) when full and not popping; done rises once halted and drained. Optional tx_count via MMIO_STORE_COUNT_EN.
module mmio_store_port
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = MMIO_BASE,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        halted,
  output logic        done,
  output logic [31:0] exit_code,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic [31:0] tx_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  mmio_state_t state;
  mmio_state_t state_nxt;

  logic          hit;
  logic          tx_st;
  logic          halt_st;
  logic          push_req;
  logic          push_acc;
  logic          push_drop;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          halt_capture;

  assign hit     = mmio_hit(data_adr, BASE_ADDR);
  assign tx_st   = mem_write && hit && (data_adr[7:0] == MMIO_TX_OFS);
  assign halt_st = mem_write && hit && (data_adr[7:0] == MMIO_HALT_OFS);

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign push_req  = tx_st && (state == RUN);
  assign push_acc  = push_req && (!fifo_full || pop);
  assign push_drop = push_req && !push_acc;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_acc),
    .push_dat (write_data),
    .pop      (pop),
    .head_dat (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    halt_capture = 1'b0;
    case (state)
      RUN: begin
        if (halt_st) begin
          state_nxt    = DRAIN;
          halt_capture = 1'b1;
        end
      end
      // Registered count: done lags the final pop by one edge.
      DRAIN: begin
        if (fifo_count == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  assign halted = (state != RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exit_code  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (halt_capture) begin
        exit_code <= write_data;
      end
      if (push_drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

`ifdef MMIO_STORE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_count <= '0;
    end else if (push_acc) begin
      tx_count <= tx_count + 32'd1;
    end
  end
`else
  assign tx_count = '0;
`endif

endmodule
